// File: rtl/function_return_stack.sv
// Return-address LIFO for CALL/RET.
// The top entry lives in its own register so the fetch mux sees a registered
// value; older entries sit in an array without reset. Entry i of the array
// holds the (i+1)-th oldest live return address, so with COUNT valid entries
// the array slots 0..COUNT-2 are live and the top register holds the newest.
module function_return_stack #(
    parameter int ADDR_WIDTH  = 12,
    parameter int STACK_DEPTH = 16,
    parameter int PTR_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] PUSH_DATA,
    input  logic                  CTRL_PUSH,
    input  logic                  CTRL_POP,
    input  logic                  CTRL_CLR,
    output logic [ADDR_WIDTH-1:0] TOP_OUT,
    output logic [PTR_WIDTH:0]    COUNT_OUT,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ERR_OVERFLOW,
    output logic                  ERR_UNDERFLOW
);

    localparam logic [PTR_WIDTH:0] C_DEPTH = (PTR_WIDTH+1)'(STACK_DEPTH);
    localparam logic [PTR_WIDTH:0] C_ONE   = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH:0] C_TWO   = (PTR_WIDTH+1)'(2);

    // Storage below the top. Sized to a full power of two so that every
    // PTR_WIDTH-bit index is in range; the last slot is never written.
    logic [ADDR_WIDTH-1:0] r_mem [0:STACK_DEPTH-1];

    logic [ADDR_WIDTH-1:0] r_top;
    logic [PTR_WIDTH:0]    r_count;
    logic                  r_ovf;
    logic                  r_unf;

    logic [ADDR_WIDTH-1:0] w_top_next;
    logic [PTR_WIDTH:0]    w_count_next;
    logic                  w_ovf_next;
    logic                  w_unf_next;
    logic                  w_mem_we;
    logic                  w_full;
    logic                  w_empty;
    logic [PTR_WIDTH:0]    w_wr_full_idx;
    logic [PTR_WIDTH:0]    w_rd_full_idx;
    logic [PTR_WIDTH-1:0]  w_wr_idx;
    logic [PTR_WIDTH-1:0]  w_rd_idx;
    logic [ADDR_WIDTH-1:0] w_below;

    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);

    // The old top is saved at slot COUNT-1 on a push; the entry below the top
    // is read from slot COUNT-2 on a pop. Both are only used when the count
    // keeps them inside 0..STACK_DEPTH-2, so the truncation never wraps.
    assign w_wr_full_idx = r_count - C_ONE;
    assign w_rd_full_idx = r_count - C_TWO;
    assign w_wr_idx      = w_wr_full_idx[PTR_WIDTH-1:0];
    assign w_rd_idx      = w_rd_full_idx[PTR_WIDTH-1:0];
    assign w_below       = r_mem[w_rd_idx];

    // Next-state decode: clear beats push/pop, then the four command cases.
    always_comb begin
        w_top_next   = r_top;
        w_count_next = r_count;
        w_ovf_next   = r_ovf;
        w_unf_next   = r_unf;
        w_mem_we     = 1'b0;
        if (CTRL_CLR) begin
            w_top_next   = '0;
            w_count_next = '0;
            w_ovf_next   = 1'b0;
            w_unf_next   = 1'b0;
        end else begin
            case ({CTRL_PUSH, CTRL_POP})
                2'b10: begin
                    if (w_full) begin
                        // Illegal push: nothing moves, oldest entry is kept.
                        w_ovf_next = 1'b1;
                    end else begin
                        // An empty stack's top is not a live entry; don't save it.
                        w_mem_we     = !w_empty;
                        w_top_next   = PUSH_DATA;
                        w_count_next = r_count + C_ONE;
                    end
                end
                2'b01: begin
                    if (w_empty) begin
                        w_unf_next = 1'b1;
                    end else if (r_count == C_ONE) begin
                        w_top_next   = '0;
                        w_count_next = '0;
                    end else begin
                        w_top_next   = w_below;
                        w_count_next = r_count - C_ONE;
                    end
                end
                2'b11: begin
                    // Tail call: overwrite the top in place. On an empty stack
                    // the pop half is illegal but the push half still lands.
                    w_top_next = PUSH_DATA;
                    if (w_empty) begin
                        w_unf_next   = 1'b1;
                        w_count_next = C_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control and top-of-stack registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_top   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_top   <= w_top_next;
            r_count <= w_count_next;
            r_ovf   <= w_ovf_next;
            r_unf   <= w_unf_next;
        end
    end

    // Entry storage: written only, never reset; reset still blocks the write.
    always_ff @(posedge clk) begin
        if (w_mem_we && !reset) begin
            r_mem[w_wr_idx] <= r_top;
        end
    end

    assign TOP_OUT       = r_top;
    assign COUNT_OUT     = r_count;
    assign FULL          = w_full;
    assign EMPTY         = w_empty;
    assign ERR_OVERFLOW  = r_ovf;
    assign ERR_UNDERFLOW = r_unf;

endmodule
